// File: rtl/seq_divider.sv
// Sequential signed 16-bit divider: restoring magnitude division over 16 cycles,
// followed by a sign-correction cycle; divide-by-zero completes immediately.
module seq_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero,
  output logic        busy,
  output logic        done
);

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   dvd_q, dvd_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W:0]     rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sgn_n_q, sgn_n_d;
  logic           sgn_d_q, sgn_d_d;
  logic [W-1:0]   quot_q, quot_d;
  logic [W-1:0]   rout_q, rout_d;
  logic           dbz_q, dbz_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [W+1:0]   shifted_c;
  logic [W+1:0]   trial_c;

  // One restoring step: the dividend magnitude register shifts out its MSB
  // into the partial remainder and collects quotient bits at its LSB.
  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    sgn_n_d   = sgn_n_q;
    sgn_d_d   = sgn_d_q;
    quot_d    = quot_q;
    rout_d    = rout_q;
    dbz_d     = dbz_q;
    shifted_c = {rem_q, dvd_q[W-1]};
    trial_c   = shifted_c - {2'b00, dvs_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quot_d  = '1;
            rout_d  = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dvd_d   = dividend[W-1] ? (~dividend + W'(1)) : dividend;
            dvs_d   = divisor[W-1]  ? (~divisor  + W'(1)) : divisor;
            sgn_n_d = dividend[W-1];
            sgn_d_d = divisor[W-1];
            rem_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!trial_c[W+1]) begin
          rem_d = trial_c[W:0];
          dvd_d = {dvd_q[W-2:0], 1'b1};
        end else begin
          rem_d = shifted_c[W:0];
          dvd_d = {dvd_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == '1) state_d = SIGN;
      end
      SIGN: begin
        quot_d  = (sgn_n_q ^ sgn_d_q) ? (~dvd_q + W'(1)) : dvd_q;
        rout_d  = sgn_n_q ? (~rem_q[W-1:0] + W'(1)) : rem_q[W-1:0];
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sgn_n_q <= 1'b0;
      sgn_d_q <= 1'b0;
      quot_q  <= '0;
      rout_q  <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sgn_n_q <= sgn_n_d;
      sgn_d_q <= sgn_d_d;
      quot_q  <= quot_d;
      rout_q  <= rout_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rout_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus queues expected results and
// completion cycles; a monitor checks every done pulse against the queue.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        busy;
  logic        done;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    int          t;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  seq_divider dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.z));
        check("done_cycle", 32'(cyc), 32'(e.t));
        check("busy_in_done", 32'(busy), 32'd1);
      end
    end
  end

  // Start one operation; lat is the expected cycle offset of done from the drive cycle.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input logic ez,
                       input int lat, input bit expect_done);
    exp_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (expect_done) begin
      e.q = eq; e.r = er; e.z = ez; e.t = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending results, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  typedef struct {
    logic [15:0] a, b, q, r;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 18};
    vecs[1] = '{16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 18};
    vecs[2] = '{16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 18};
    vecs[3] = '{16'd5,    16'd0,    16'hFFFF, 16'h0005, 1'b1, 1};
    vecs[4] = '{16'd9,    16'd3,    16'h0003, 16'h0000, 1'b0, 18};
    vecs[5] = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 18};
    vecs[6] = '{16'h8000, 16'd1,    16'h8000, 16'h0000, 1'b0, 18};
    vecs[7] = '{16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0, 18};
    vecs[8] = '{16'd7,    16'h8000, 16'h0000, 16'h0007, 1'b0, 18};

    #1;
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].lat, 1'b1);
      wait_idle("vector");
    end

    // A start pulse during CALC must be ignored; results hold meanwhile.
    issue(16'd100, 16'd7, 16'h000E, 16'h0002, 1'b0, 18, 1'b1);
    repeat (3) @(negedge clk);
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    check("busy_mid_op", 32'(busy), 32'd1);
    check("hold_quotient", 32'(quotient), 32'h0000);
    check("hold_remainder", 32'(remainder), 32'h0007);
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'd1234;
    divisor  = 16'd3;
    wait_idle("ignored_start");

    // Start held high: a second operation begins on the first IDLE edge after DONE.
    begin
      exp_t e;
      @(negedge clk);
      dividend = 16'd9;
      divisor  = 16'd3;
      start    = 1'b1;
      e.q = 16'h0003; e.r = 16'h0000; e.z = 1'b0; e.t = cyc + 18;
      sb.push_back(e);
      e.t = cyc + 37;
      sb.push_back(e);
      repeat (20) @(negedge clk);
      start = 1'b0;
      wait_idle("held_start");
    end

    // Reset mid-operation aborts without a completion pulse.
    issue(16'd100, 16'd7, 16'h0000, 16'h0000, 1'b0, 18, 1'b0);
    repeat (6) @(negedge clk);
    check("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    issue(16'd81, 16'd9, 16'h0009, 16'h0000, 1'b0, 18, 1'b1);
    wait_idle("after_reset");

    repeat (25) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
